// File: rtl/load_arb_pkg.sv
// load_arb_pkg: shared state encoding and requester ids for the load channel arbiter
package load_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_K, ARB_GNT_I} arb_state_t;
  localparam logic REQ_K = 1'b0;
  localparam logic REQ_I = 1'b1;
endpackage

// File: rtl/arb_burst_counter.sv
// arb_burst_counter: beats-remaining counter for one burst; a zero length loads as a single beat
module arb_burst_counter #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_beat,
  output logic             o_last
);
  logic [LEN_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) r_cnt <= '0;
    else if (i_load) r_cnt <= (i_len == '0) ? '0 : i_len - 1'b1;
    else if (i_beat && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_last = (r_cnt == '0);
endmodule

// File: rtl/load_channel_arbiter.sv
// load_channel_arbiter: burst-locked round-robin sharing of the external load channel between K and I loaders.
// Define LOAD_ARB_PERF_EN to add saturating stall/transfer performance counters.
module load_channel_arbiter
  import load_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  k_req,
  input  logic [LEN_W-1:0]      k_len,
  input  logic                  i_req,
  input  logic [LEN_W-1:0]      i_len,
  input  logic                  ext_valid,
  output logic                  ext_ready,
  input  logic [DATA_WIDTH-1:0] ext_data,
  output logic                  k_valid,
  input  logic                  k_ready,
  output logic [DATA_WIDTH-1:0] k_data,
  output logic                  i_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] i_data,
  output logic                  k_gnt,
  output logic                  i_gnt,
  output logic                  k_done,
  output logic                  i_done,
  output logic                  busy
`ifdef LOAD_ARB_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_xfer_cnt
`endif
);
  arb_state_t       r_state, w_next;
  logic             r_last_winner, r_k_done, r_i_done;
  logic             w_beat, w_is_last, w_last, w_arb, w_kr, w_ir, w_win_k, w_win_i, w_load;
  logic [LEN_W-1:0] w_len;
  assign k_gnt     = (r_state == ARB_GNT_K);
  assign i_gnt     = (r_state == ARB_GNT_I);
  assign busy      = k_gnt | i_gnt;
  assign k_data    = ext_data;
  assign i_data    = ext_data;
  assign k_valid   = ext_valid & k_gnt;
  assign i_valid   = ext_valid & i_gnt;
  assign ext_ready = (k_gnt & k_ready) | (i_gnt & i_ready);
  assign k_done    = r_k_done;
  assign i_done    = r_i_done;
  assign w_beat    = ext_valid & ext_ready;
  assign w_last    = w_beat & w_is_last;
  assign w_arb     = (r_state == ARB_IDLE) | w_last;
  // the finishing owner's own request is masked so the other side wins back-to-back
  assign w_kr      = k_req & ~k_gnt;
  assign w_ir      = i_req & ~i_gnt;
  assign w_win_k   = w_kr & (~w_ir | (r_last_winner == REQ_I));
  assign w_win_i   = w_ir & (~w_kr | (r_last_winner == REQ_K));
  assign w_load    = w_arb & (w_win_k | w_win_i);
  assign w_len     = w_win_k ? k_len : i_len;
  assign w_next    = !w_arb ? r_state : w_win_k ? ARB_GNT_K : w_win_i ? ARB_GNT_I : ARB_IDLE;
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_state       <= ARB_IDLE;
      r_last_winner <= REQ_I;
      r_k_done      <= 1'b0;
      r_i_done      <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_k_done <= w_last & k_gnt;
      r_i_done <= w_last & i_gnt;
      if (w_load) r_last_winner <= w_win_k ? REQ_K : REQ_I;
    end
  end
  arb_burst_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk      (clk),
    .arst_n_in(arst_n_in),
    .i_load   (w_load),
    .i_len    (w_len),
    .i_beat   (w_beat),
    .o_last   (w_is_last)
  );
`ifdef LOAD_ARB_PERF_EN
  logic [31:0] r_stall, r_xfer;
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_stall <= '0;
      r_xfer  <= '0;
    end else begin
      if (busy && !w_beat && r_stall != '1) r_stall <= r_stall + 1'b1;
      if (w_beat && r_xfer != '1) r_xfer <= r_xfer + 1'b1;
    end
  end
  assign perf_stall_cnt = r_stall;
  assign perf_xfer_cnt  = r_xfer;
`endif
endmodule

// File: tb/tb_load_channel_arbiter.sv
// tb_load_channel_arbiter: randomized protocol-following requesters checked against a burst-level reference model
module tb_load_channel_arbiter;
  logic        clk = 1'b0, arst_n_in = 1'b0;
  logic        k_req = 0, i_req = 0, ext_valid = 0, k_ready = 0, i_ready = 0;
  logic [7:0]  k_len = 0, i_len = 0;
  logic [15:0] ext_data = 0;
  logic        ext_ready, k_valid, i_valid, k_gnt, i_gnt, k_done, i_done, busy;
  logic [15:0] k_data, i_data;
`ifdef LOAD_ARB_PERF_EN
  logic [31:0] perf_stall_cnt, perf_xfer_cnt;
`endif
  int n_cmp = 0, n_err = 0;
  int m_own, m_rem, m_lw;
  bit m_kd, m_id, k_act, i_act;
  longint m_stall, m_xfer;

  load_channel_arbiter dut (
    .clk(clk), .arst_n_in(arst_n_in),
    .k_req(k_req), .k_len(k_len), .i_req(i_req), .i_len(i_len),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_data(ext_data),
    .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .k_gnt(k_gnt), .i_gnt(i_gnt), .k_done(k_done), .i_done(i_done), .busy(busy)
`ifdef LOAD_ARB_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_xfer_cnt(perf_xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // owner: 0 none, 1 K, 2 I; m_rem counts beats still owed including the current one
  task automatic model_reset();
    m_own = 0; m_rem = 0; m_lw = 2; m_kd = 0; m_id = 0; m_stall = 0; m_xfer = 0;
    k_act = 0; i_act = 0;
  endtask

  task automatic model_step();
    bit kg, ig, beat, fin, ck, ci;
    kg = (m_own == 1); ig = (m_own == 2);
    beat = ext_valid && ((kg && k_ready) || (ig && i_ready));
    fin = beat && (m_rem == 1);
    if (m_own != 0 && !beat) m_stall++;
    if (beat) m_xfer++;
    m_kd = fin && kg; m_id = fin && ig;
    if (m_own == 0 || fin) begin
      ck = k_req && !kg; ci = i_req && !ig;
      if (ck && (!ci || m_lw == 2)) begin m_own = 1; m_rem = (k_len == 0) ? 1 : int'(k_len); m_lw = 1; end
      else if (ci) begin m_own = 2; m_rem = (i_len == 0) ? 1 : int'(i_len); m_lw = 2; end
      else m_own = 0;
    end else if (beat) m_rem--;
  endtask

  function automatic logic [7:0] obs();
    return {k_gnt, i_gnt, busy, ext_ready, k_valid, i_valid, k_done, i_done};
  endfunction

  function automatic logic [7:0] expv();
    bit kg, ig;
    kg = (m_own == 1); ig = (m_own == 2);
    return {kg, ig, kg | ig, (kg & k_ready) | (ig & i_ready), ext_valid & kg, ext_valid & ig, m_kd, m_id};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    arst_n_in = 0; k_req = 0; i_req = 0; ext_valid = 0; k_ready = 0; i_ready = 0;
    model_reset();
    #1 check("reset_outs", obs(), 8'h00);
    @(negedge clk) arst_n_in = 1;
  endtask

  task automatic run(input int n, input int pv, input int pr, input int pk, input int pi,
                     input int kl, input int il, input int prst);
    do_reset();
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_step();
      #1;
      if ($urandom_range(99) < prst) begin
        arst_n_in = 0; k_req = 0; i_req = 0;
        model_reset();
        #1 check("async_reset", obs(), 8'h00);
        arst_n_in = 1;
      end
      if (m_kd) begin k_act = 0; k_req = 0; end
      if (m_id) begin i_act = 0; i_req = 0; end
      if (!k_act && $urandom_range(99) < pk) begin
        k_act = 1; k_req = 1; k_len = (kl < 0) ? 8'($urandom_range(6)) : 8'(kl);
      end
      if (!i_act && $urandom_range(99) < pi) begin
        i_act = 1; i_req = 1; i_len = (il < 0) ? 8'($urandom_range(6)) : 8'(il);
      end
      ext_valid = ($urandom_range(99) < pv);
      k_ready = ($urandom_range(99) < pr);
      i_ready = ($urandom_range(99) < pr);
      ext_data = 16'($urandom);
      #1;
      check("handshake", obs(), expv());
      check("data", {k_data, i_data}, {ext_data, ext_data});
`ifdef LOAD_ARB_PERF_EN
      check("perf", {perf_stall_cnt, perf_xfer_cnt}, {32'(m_stall), 32'(m_xfer)});
`endif
    end
  endtask

  initial begin
    model_reset();
    run(30, 100, 100, 100, 0, 12, 0, 0);
    run(30, 100, 100, 100, 100, 3, 4, 0);
    run(40, 100, 100, 100, 100, 2, 2, 0);
    run(30, 50, 100, 100, 0, 4, 0, 0);
    run(20, 100, 100, 0, 100, 0, 0, 0);
    run(60, 100, 100, 100, 0, 5, 0, 4);
    run(3000, 70, 70, 40, 40, -1, -1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
